floor_request_queue: RTL and testbench

- Upstream stage of the elevator FSM: conditions raw floor-call buttons (ground, first, second), latches pending calls and issues one target floor at a time over a valid/ack handshake.
- Runs on the same slow clock as the FSM.
- Its pending bits also feed the call LEDs.
- Selection is direction-preserving (SCAN) over floors 0..2.

---
 rtl/elevator_pkg.sv | 56 +++++
 rtl/button_debouncer.sv | 42 ++++
 rtl/floor_request_queue.sv | 129 ++++++++++++
 tb/tb_floor_request_queue.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared floor, state and direction definitions for the elevator control path.
package elevator_pkg;

  localparam int unsigned NUM_FLOORS = 3;
  localparam int unsigned FLOOR_W    = 2;

  localparam logic [FLOOR_W-1:0] FLOOR_G = 2'd0;
  localparam logic [FLOOR_W-1:0] FLOOR_1 = 2'd1;
  localparam logic [FLOOR_W-1:0] FLOOR_2 = 2'd2;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  // Encoding 3 is never driven by the FSM; fold it onto the top floor.
  function automatic logic [FLOOR_W-1:0] clamp_floor(input logic [FLOOR_W-1:0] f);
    return (f == 2'd3) ? FLOOR_2 : f;
  endfunction

  function automatic logic [NUM_FLOORS-1:0] floor_bit(input logic [FLOOR_W-1:0] f);
    return NUM_FLOORS'(1) << f;
  endfunction

  function automatic logic [NUM_FLOORS-1:0] above_mask(input logic [FLOOR_W-1:0] f);
    logic [NUM_FLOORS-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_FLOORS; i++) m[i] = (FLOOR_W'(i) > f);
    return m;
  endfunction

  function automatic logic [NUM_FLOORS-1:0] below_mask(input logic [FLOOR_W-1:0] f);
    logic [NUM_FLOORS-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_FLOORS; i++) m[i] = (FLOOR_W'(i) < f);
    return m;
  endfunction

  function automatic logic [FLOOR_W-1:0] lowest_floor(input logic [NUM_FLOORS-1:0] m);
    logic [FLOOR_W-1:0] r;
    r = FLOOR_G;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) if (m[i]) r = FLOOR_W'(i);
    return r;
  endfunction

  function automatic logic [FLOOR_W-1:0] highest_floor(input logic [NUM_FLOORS-1:0] m);
    logic [FLOOR_W-1:0] r;
    r = FLOOR_G;
    for (int i = 0; i < NUM_FLOORS; i++) if (m[i]) r = FLOOR_W'(i);
    return r;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchronizes one raw call button, debounces it and emits a one-cycle press pulse
// on each accepted 0->1 transition.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);

  logic             sync_q1;
  logic             sync_q2;
  logic             level_q;
  logic [CNT_W-1:0] cnt_q;

  // Level flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press   <= 1'b0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
      press   <= 1'b0;
      if (sync_q2 == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        cnt_q   <= '0;
        level_q <= sync_q2;
        press   <= sync_q2;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/floor_request_queue.sv
// Latches debounced floor calls and issues one target at a time to the elevator FSM
// using direction-preserving (SCAN) selection over a valid/arrive handshake.
module floor_request_queue
  import elevator_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  g_f,
  input  logic                  f_f,
  input  logic                  s_f,
  input  logic                  emerg_in,
  input  logic [FLOOR_W-1:0]    cur_floor,
  input  logic                  arrive,
  output logic                  req_valid,
  output logic [FLOOR_W-1:0]    req_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  dir_up
);

  logic [NUM_FLOORS-1:0] press;
  logic [NUM_FLOORS-1:0] raw_btn;

  assign raw_btn = {s_f, f_f, g_f};

  for (genvar i = 0; i < NUM_FLOORS; i++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_debouncer (
      .clk   (clk),
      .reset (reset),
      .raw   (raw_btn[i]),
      .press (press[i])
    );
  end

  state_t                state_q, state_d;
  logic [NUM_FLOORS-1:0] pending_d;
  logic                  req_valid_d;
  logic [FLOOR_W-1:0]    req_floor_d;
  logic                  dir_up_d;

  logic [FLOOR_W-1:0]    cur;
  logic [NUM_FLOORS-1:0] cur_bit;
  logic [NUM_FLOORS-1:0] cand;
  logic [NUM_FLOORS-1:0] up_m;
  logic [NUM_FLOORS-1:0] dn_m;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      pending   <= '0;
      req_valid <= 1'b0;
      req_floor <= FLOOR_G;
      dir_up    <= DIR_UP;
    end else begin
      state_q   <= state_d;
      pending   <= pending_d;
      req_valid <= req_valid_d;
      req_floor <= req_floor_d;
      dir_up    <= dir_up_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pending_d   = pending;
    req_valid_d = req_valid;
    req_floor_d = req_floor;
    dir_up_d    = dir_up;

    cur     = clamp_floor(cur_floor);
    cur_bit = floor_bit(cur);
    cand    = pending & ~cur_bit;
    up_m    = cand & above_mask(cur);
    dn_m    = cand & below_mask(cur);

    if (emerg_in) begin
      pending_d   = '0;
      req_valid_d = 1'b0;
      state_d     = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          // A call for the floor we are standing on is served without issuing.
          pending_d   = cand | (press & ~cur_bit);
          req_valid_d = 1'b0;
          if (dir_up == DIR_UP) begin
            if (|up_m) begin
              req_floor_d = lowest_floor(up_m);
              req_valid_d = 1'b1;
              state_d     = ISSUE;
            end else if (|dn_m) begin
              req_floor_d = highest_floor(dn_m);
              req_valid_d = 1'b1;
              state_d     = ISSUE;
              dir_up_d    = DIR_DOWN;
            end
          end else begin
            if (|dn_m) begin
              req_floor_d = highest_floor(dn_m);
              req_valid_d = 1'b1;
              state_d     = ISSUE;
            end else if (|up_m) begin
              req_floor_d = lowest_floor(up_m);
              req_valid_d = 1'b1;
              state_d     = ISSUE;
              dir_up_d    = DIR_UP;
            end
          end
        end
        ISSUE: begin
          // Clear is applied after the set so an arrive beats a same-floor press.
          pending_d = pending | press;
          if (arrive) begin
            pending_d   = pending_d & ~floor_bit(req_floor);
            req_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_floor_request_queue.sv
// Directed bench for floor_request_queue with hand-computed expectations.
module tb_floor_request_queue;

  logic       clk;
  logic       reset;
  logic       g_f, f_f, s_f;
  logic       emerg_in;
  logic [1:0] cur_floor;
  logic       arrive;
  logic       req_valid;
  logic [1:0] req_floor;
  logic [2:0] pending;
  logic       dir_up;

  int vectors;
  int miscompares;

  floor_request_queue #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .g_f       (g_f),
    .f_f       (f_f),
    .s_f       (s_f),
    .emerg_in  (emerg_in),
    .cur_floor (cur_floor),
    .arrive    (arrive),
    .req_valid (req_valid),
    .req_floor (req_floor),
    .pending   (pending),
    .dir_up    (dir_up)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [2:0] p, input logic v,
                         input logic [1:0] f, input logic d);
    chk({tag, ".pending"},   pending,           p);
    chk({tag, ".req_valid"}, 3'(req_valid),     3'(v));
    chk({tag, ".req_floor"}, 3'(req_floor),     3'(f));
    chk({tag, ".dir_up"},    3'(dir_up),        3'(d));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset     = 1'b0;
    g_f       = 1'b0;
    f_f       = 1'b0;
    s_f       = 1'b0;
    emerg_in  = 1'b0;
    cur_floor = 2'd0;
    arrive    = 1'b0;

    // Reset and idle
    tick(2);
    chk_out("reset", 3'b000, 1'b0, 2'd0, 1'b1);
    reset = 1'b1;
    tick(10);
    chk_out("idle", 3'b000, 1'b0, 2'd0, 1'b1);

    // Short glitch: 3 samples high is not enough
    s_f = 1'b1;
    tick(3);
    s_f = 1'b0;
    tick(10);
    chk_out("glitch", 3'b000, 1'b0, 2'd0, 1'b1);

    // Held press from floor 0: pulse after 6 edges, pending +1, valid +2
    s_f = 1'b1;
    tick(6);
    chk("lat.pulse_cycle", pending, 3'b000);
    tick(1);
    chk("lat.pending", pending, 3'b100);
    chk("lat.no_valid_yet", 3'(req_valid), 3'd0);
    tick(1);
    chk_out("lat.issue", 3'b100, 1'b1, 2'd2, 1'b1);
    s_f = 1'b0;
    tick(2);
    cur_floor = 2'd2;
    arrive    = 1'b1;
    tick(1);
    arrive = 1'b0;
    chk_out("lat.arrive", 3'b000, 1'b0, 2'd2, 1'b1);
    tick(8);

    // SCAN: from floor 1 going up, calls on 0 and 2
    cur_floor = 2'd1;
    g_f = 1'b1;
    s_f = 1'b1;
    tick(7);
    chk("scan.pending", pending, 3'b101);
    tick(1);
    chk_out("scan.first", 3'b101, 1'b1, 2'd2, 1'b1);
    g_f = 1'b0;
    s_f = 1'b0;
    cur_floor = 2'd2;
    arrive    = 1'b1;
    tick(1);
    arrive = 1'b0;
    chk_out("scan.arrive2", 3'b001, 1'b0, 2'd2, 1'b1);
    tick(1);
    chk_out("scan.reverse", 3'b001, 1'b1, 2'd0, 1'b0);

    // Collision: press on floor 0 lands in the arrive cycle for floor 0
    tick(8);
    chk_out("coll.hold", 3'b001, 1'b1, 2'd0, 1'b0);
    g_f = 1'b1;
    tick(6);
    cur_floor = 2'd0;
    arrive    = 1'b1;
    tick(1);
    arrive = 1'b0;
    chk_out("coll.clear_wins", 3'b000, 1'b0, 2'd0, 1'b0);
    g_f = 1'b0;
    tick(1);
    chk_out("coll.idle", 3'b000, 1'b0, 2'd0, 1'b0);
    tick(8);

    // Same-floor call while idle at floor 1
    cur_floor = 2'd1;
    f_f = 1'b1;
    tick(7);
    chk("same.pending", pending, 3'b000);
    tick(1);
    chk("same.no_valid", 3'(req_valid), 3'd0);
    f_f = 1'b0;
    tick(8);

    // Hold during ISSUE; heading down with nothing below flips to up
    s_f = 1'b1;
    tick(8);
    chk_out("hold.issue2", 3'b100, 1'b1, 2'd2, 1'b1);
    s_f = 1'b0;
    g_f = 1'b1;
    tick(7);
    chk_out("hold.g_latched", 3'b101, 1'b1, 2'd2, 1'b1);
    g_f = 1'b0;
    tick(3);
    chk("hold.still2", 3'(req_floor), 3'd2);
    cur_floor = 2'd2;
    arrive    = 1'b1;
    tick(1);
    arrive = 1'b0;
    chk_out("hold.arrive2", 3'b001, 1'b0, 2'd2, 1'b1);
    tick(1);
    chk_out("hold.issue0", 3'b001, 1'b1, 2'd0, 1'b0);

    // Emergency with pending=101 in ISSUE
    s_f = 1'b1;
    tick(7);
    chk_out("emerg.pre", 3'b101, 1'b1, 2'd0, 1'b0);
    s_f = 1'b0;
    emerg_in = 1'b1;
    tick(1);
    chk("emerg.pending", pending, 3'b000);
    chk("emerg.valid", 3'(req_valid), 3'd0);
    chk("emerg.dir_held", 3'(dir_up), 3'd0);
    tick(8);
    f_f = 1'b1;
    tick(8);
    chk("emerg.ignored", pending, 3'b000);
    emerg_in = 1'b0;
    tick(4);
    chk("emerg.no_refire", pending, 3'b000);
    chk("emerg.no_refire_v", 3'(req_valid), 3'd0);
    f_f = 1'b0;
    tick(8);

    // Fresh press after emergency, cur_floor=3 treated as floor 2
    cur_floor = 2'd3;
    g_f = 1'b1;
    tick(8);
    chk_out("post.issue0", 3'b001, 1'b1, 2'd0, 1'b0);
    g_f = 1'b0;

    // Reset in ISSUE with a simultaneous arrive
    reset  = 1'b0;
    arrive = 1'b1;
    tick(1);
    chk_out("rst_mid", 3'b000, 1'b0, 2'd0, 1'b1);
    reset  = 1'b1;
    arrive = 1'b0;
    tick(2);
    chk_out("rst_after", 3'b000, 1'b0, 2'd0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
